// File: rtl/mux_pkg.sv
// Shared constants and types for the registered 4-to-1 lane selector.
// Provides the lane count, select width and lane index type.
package mux_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef logic [SEL_W-1:0] lane_sel_t;

endpackage

// File: rtl/mux_4_to_1_comb.sv
// Combinational 4-lane selector, no state.
// Ports: data (packed lanes, lane 0 at LSBs), sel (lane index), lane (chosen lane).
module mux_4_to_1_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [NUM_LANES*WIDTH-1:0] data,
  input  lane_sel_t                  sel,
  output logic [WIDTH-1:0]           lane
);

  // An unknown select falls to the default so simulation shows X.
  always_comb begin
    lane = 'x;
    case (sel)
      2'd0:    lane = data[0*WIDTH +: WIDTH];
      2'd1:    lane = data[1*WIDTH +: WIDTH];
      2'd2:    lane = data[2*WIDTH +: WIDTH];
      2'd3:    lane = data[3*WIDTH +: WIDTH];
      default: lane = 'x;
    endcase
  end

endmodule

// File: rtl/mux_4_to_1.sv
// Registered 4-to-1 data selector with active-low enable (74x153 style).
// Ports: clk, rst (sync, active-high), enable_ (active-low), signal_i (lane select),
// data (packed lanes), signal_o (registered selected lane, 0 when disabled/reset).
module mux_4_to_1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_,
  input  lane_sel_t                  signal_i,
  input  logic [NUM_LANES*WIDTH-1:0] data,
  output logic [WIDTH-1:0]           signal_o
);

  if (WIDTH < 1) begin : g_width_chk
    $error("mux_4_to_1: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] lane;

  mux_4_to_1_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .data (data),
    .sel  (signal_i),
    .lane (lane)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      signal_o <= '0;
    end else if (enable_) begin
      signal_o <= '0;
    end else begin
      signal_o <= lane;
    end
  end

endmodule

// File: tb/tb_mux_4_to_1.sv
// Directed self-checking bench for mux_4_to_1 (WIDTH=1 and WIDTH=8).
// Expected values are hand-computed constants.
module tb_mux_4_to_1;

  logic       clk = 1'b0;
  logic       rst;
  logic       en1_, en8_;
  logic [1:0] sel1, sel8;
  logic [3:0] d1;
  logic [31:0] d8;
  logic       y1;
  logic [7:0] y8;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_4_to_1 #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .enable_  (en1_),
    .signal_i (sel1),
    .data     (d1),
    .signal_o (y1)
  );

  mux_4_to_1 #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .enable_  (en8_),
    .signal_i (sel8),
    .data     (d8),
    .signal_o (y8)
  );

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic vec1(input string tag,
                      input logic [1:0] s,
                      input logic [3:0] d,
                      input logic       e);
    sel1 = s;
    d1   = d;
    tick();
    check(tag, {7'b0, y1}, {7'b0, e});
  endtask

  initial begin
    rst  = 1'b1;
    en1_ = 1'b0;
    en8_ = 1'b0;
    sel1 = 2'd1;
    sel8 = 2'd3;
    d1   = 4'b1111;
    d8   = 32'hDDCC_BBAA;
    tick();
    check("reset_w1", {7'b0, y1}, 8'h00);
    check("reset_w8", y8, 8'h00);
    rst = 1'b0;

    vec1("sel0_lo", 2'd0, 4'b1110, 1'b0);
    vec1("sel0_hi", 2'd0, 4'b0001, 1'b1);
    vec1("sel1_lo", 2'd1, 4'b1101, 1'b0);
    vec1("sel1_hi", 2'd1, 4'b0010, 1'b1);
    vec1("sel2_lo", 2'd2, 4'b1011, 1'b0);
    vec1("sel2_hi", 2'd2, 4'b0100, 1'b1);
    vec1("sel3_lo", 2'd3, 4'b0111, 1'b0);
    vec1("sel3_hi", 2'd3, 4'b1000, 1'b1);

    en1_ = 1'b1;
    vec1("dis_all1", 2'd3, 4'b1111, 1'b0);
    en1_ = 1'b0;
    vec1("reenable", 2'd3, 4'b1111, 1'b1);

    vec1("pre_rst", 2'd1, 4'b0010, 1'b1);
    rst = 1'b1;
    vec1("rst_mid", 2'd1, 4'b0010, 1'b0);
    rst = 1'b0;
    vec1("post_rst", 2'd1, 4'b0010, 1'b1);
    rst = 1'b1;
    en1_ = 1'b0;
    vec1("rst_en", 2'd1, 4'b0010, 1'b0);
    rst = 1'b0;

    sel8 = 2'd0;
    tick();
    check("w8_lane0", y8, 8'hAA);
    sel8 = 2'd1;
    tick();
    check("w8_lane1", y8, 8'hBB);
    sel8 = 2'd2;
    tick();
    check("w8_lane2", y8, 8'hCC);
    sel8 = 2'd3;
    tick();
    check("w8_lane3", y8, 8'hDD);

    en8_ = 1'b1;
    tick();
    check("w8_dis", y8, 8'h00);
    en8_ = 1'b0;
    sel8 = 2'd2;
    d8   = 32'h1234_5678;
    tick();
    check("w8_newdata", y8, 8'h34);
    rst = 1'b1;
    tick();
    check("w8_rst", y8, 8'h00);
    rst = 1'b0;
    tick();
    check("w8_post_rst", y8, 8'h34);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_4_to_1.md
# mux_4_to_1

Registered 4-to-1 multiplexer with an active-low enable, modelled on the 74x153 data selector. A 2-bit select (`signal_i`) picks one of four data lanes from a packed bus, and the chosen lane is presented on `signal_o` one clock later. The block is a leaf datapath element used wherever a small registered lane select is needed. Disabled or reset operation forces the output low.

## Interface
Parameters:
- `WIDTH`, default 1: bits per data lane; the output has the same width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `enable_`  input  1  active-low enable; 0 = select active, 1 = output forced to 0.
- `signal_i`  input  2  lane select, 0..3.
- `data`  input  4*WIDTH  packed lanes; lane k = `data[k*WIDTH +: WIDTH]`; lane 0 at the LSBs.
- `signal_o`  output  WIDTH  registered selected lane.

## Operation
- Rising edge with `rst`=1: `signal_o` <= 0. Reset has priority over all other inputs.
- Rising edge with `rst`=0 and `enable_`=1: `signal_o` <= 0.
- Rising edge with `rst`=0 and `enable_`=0: `signal_o` <= lane `signal_i` of `data`.
  - `signal_i`=0 selects `data[WIDTH-1:0]`.
  - `signal_i`=3 selects `data[4*WIDTH-1:3*WIDTH]`.
- No internal state other than the output register. No FSM, no handshake.
- Any X/Z on `signal_i` while enabled drives X on the next output in simulation. Synthesis behaviour for this case is don't-care.
- Unselected lanes have no effect on the output.

## Timing
- Latency: exactly 1 clock from inputs sampled at edge N to `signal_o` valid after edge N.
- Output is glitch-free: `signal_o` changes only on `clk` rising edges.
- Changes to `enable_`, `signal_i` and `data` take effect only at the next rising edge.
- Throughput: a new selection every cycle.
- Reset asserted mid-stream: output is 0 after the first edge with `rst`=1. The first output after deassertion reflects the inputs sampled at that edge.
- Reset value of `signal_o`: all zeros.

## Structure
- Shared package `mux_pkg`:
  - `NUM_LANES` = 4
  - `SEL_W` = 2
  - Lane index typedef `lane_sel_t` (logic [SEL_W-1:0]).
- The combinational selector is a natural sub-module, `mux_4_to_1_comb`.
  - It takes `data` and the select and produces the chosen lane with no registers.
  - The top adds the enable gating, reset and output register.
- Add an elaboration-time assertion that `WIDTH` >= 1.

## Test plan
Use `WIDTH`=1, `enable_`=0 and no reset unless stated. Check `signal_o` one cycle after each stimulus.
- Select 0: `signal_i`=00, `data`=1110 -> 0; then `data`=0001 -> 1.
- Select 1: `signal_i`=01, `data`=1101 -> 0; then `data`=0010 -> 1.
- Select 2 and 3:
  - `signal_i`=10, `data`=1011 -> 0; then `data`=0100 -> 1.
  - `signal_i`=11, `data`=0111 -> 0; then `data`=1000 -> 1.
- Disable: `enable_`=1, `signal_i`=11, `data`=1111 -> 0. Return `enable_` to 0 -> 1 on the next edge.
- Reset: with selected lane = 1, assert `rst` for one cycle -> 0. Deassert -> 1 on the next edge. Also check `rst`=1 with `enable_`=0 yields 0.
- Wide lanes: `WIDTH`=8, `data`=0xDD_CC_BB_AA, sweep `signal_i` 0..3 every cycle -> AA, BB, CC, DD, each with 1-cycle latency.
